aes_key_schedule: RTL and testbench

- Sequential AES key-schedule engine. Supports AES-128, AES-192 and AES-256, selected per job at run time.
- Generates one 32-bit schedule word per cycle using a single 4-byte s_box bank.
- Assembles the words into 128-bit round keys and streams them to the cipher datapath over a valid/ready interface.
- Successor to the ready-pulse-stepped 128-bit expander: proper clock and reset, handshake, backpressure, abort and multiple key lengths.

---
 rtl/aes_key_schedule_if.sv | 26 ++
 rtl/aes_key_schedule.sv | 226 ++++++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_schedule_if.sv
// Job request / round-key stream bundle between the key-schedule engine and its user.
interface aes_key_schedule_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         abort;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         err;

  // Master drives jobs and consumes round keys.
  modport master (
    output start, key_len, key_in, abort, rk_ready,
    input  busy, rk_valid, rk_data, rk_idx, rk_last, err
  );

  // Slave is the key-schedule engine.
  modport slave (
    input  start, key_len, key_in, abort, rk_ready,
    output busy, rk_valid, rk_data, rk_idx, rk_last, err
  );
endinterface

// File: rtl/aes_key_schedule.sv
// Sequential AES-128/192/256 key expansion: one schedule word per cycle through a
// single 4-byte S-box bank, packed into 128-bit round keys on a valid/ready stream.
module aes_key_schedule #(
  parameter int unsigned ENABLE_192 = 1,
  parameter int unsigned ENABLE_256 = 1
) (
  input logic              clk,
  input logic              rst_n,
  aes_key_schedule_if.slave kif
);

  typedef enum logic [1:0] {IDLE, GEN, FLUSH} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  state_t       state_q, state_d;
  logic [255:0] key_q, key_d;       // remaining key words, consumed from the top
  logic [3:0]   nk_q, nk_d;
  logic [3:0]   nr_q, nr_d;
  logic [5:0]   i_q, i_d;           // index of the next word to produce
  logic [2:0]   mod_q, mod_d;       // i mod Nk, tracked incrementally
  logic [7:0]   rcon_q, rcon_d;     // Rcon value for the next i mod Nk == 0 word
  logic [1:0]   asm_q, asm_d;       // words already parked in the holding register
  logic [3:0]   r_q, r_d;           // round number of the key being assembled
  logic [127:0] rk_data_q, rk_data_d;
  logic [3:0]   rk_idx_q, rk_idx_d;
  logic         rk_valid_q, rk_valid_d;
  logic         rk_last_q, rk_last_d;
  logic         err_q, err_d;
  logic [31:0]  win_q [8];          // win_q[k] = w[i-1-k]
  logic [31:0]  hold_q [3];         // first three words of the round in progress

  logic [31:0] w_prev, w_old, sub_in, sub_out, temp, w_new;
  logic [2:0]  old_sel;
  logic        is_key, out_free, adv, load, last_word, len_ok, handshake;

  // w[i-Nk] sits at window slot Nk-1; Nk=8 wraps the 3-bit slot index to 7.
  assign old_sel   = nk_q[2:0] - 3'd1;
  assign w_prev    = win_q[0];
  assign w_old     = win_q[old_sel];
  assign is_key    = (i_q < {2'b00, nk_q});
  assign sub_in    = (mod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign handshake = rk_valid_q && kif.rk_ready;
  assign out_free  = !rk_valid_q || kif.rk_ready;
  // The 4th word of a round may only be produced if the output register can take it.
  assign adv       = (state_q == GEN) && !kif.abort && ((asm_q != 2'd3) || out_free);
  assign load      = adv && (asm_q == 2'd3);
  assign last_word = (i_q == {nr_q, 2'b11});
  assign len_ok    = (kif.key_len == 2'b00) ||
                     ((kif.key_len == 2'b01) && (ENABLE_192 != 0)) ||
                     ((kif.key_len == 2'b10) && (ENABLE_256 != 0));

  // Shared 4-byte S-box bank.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign sub_out[8*gi +: 8] = SBOX[sub_in[8*gi +: 8]];
  end

  // Schedule word recurrence for the current index.
  always_comb begin
    temp = w_prev;
    if (mod_q == 3'd0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if ((nk_q == 4'd8) && (mod_q == 3'd4)) begin
      temp = sub_out;
    end
    w_new = is_key ? key_q[255:224] : (w_old ^ temp);
  end

  // FSM next state, word counters and output register updates.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    nk_d       = nk_q;
    nr_d       = nr_q;
    i_d        = i_q;
    mod_d      = mod_q;
    rcon_d     = rcon_q;
    asm_d      = asm_q;
    r_d        = r_q;
    rk_data_d  = rk_data_q;
    rk_idx_d   = rk_idx_q;
    rk_valid_d = rk_valid_q;
    rk_last_d  = rk_last_q;
    err_d      = 1'b0;
    if (kif.abort) begin
      state_d    = IDLE;
      rk_valid_d = 1'b0;
      rk_last_d  = 1'b0;
      asm_d      = 2'd0;
    end else begin
      if (handshake) begin
        rk_valid_d = 1'b0;
        rk_last_d  = 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (kif.start) begin
            if (len_ok) begin
              key_d   = kif.key_in;
              nk_d    = (kif.key_len == 2'b00) ? 4'd4  : (kif.key_len == 2'b01) ? 4'd6  : 4'd8;
              nr_d    = (kif.key_len == 2'b00) ? 4'd10 : (kif.key_len == 2'b01) ? 4'd12 : 4'd14;
              i_d     = 6'd0;
              mod_d   = 3'd0;
              rcon_d  = 8'h01;
              asm_d   = 2'd0;
              r_d     = 4'd0;
              state_d = GEN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        GEN: begin
          if (adv) begin
            i_d   = i_q + 6'd1;
            key_d = {key_q[223:0], 32'h0};
            mod_d = ({1'b0, mod_q} == (nk_q - 4'd1)) ? 3'd0 : mod_q + 3'd1;
            if (!is_key && (mod_q == 3'd0)) begin
              rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
            if (load) begin
              rk_data_d  = {hold_q[0], hold_q[1], hold_q[2], w_new};
              rk_idx_d   = r_q;
              rk_last_d  = (r_q == nr_q);
              rk_valid_d = 1'b1;
              r_d        = r_q + 4'd1;
              asm_d      = 2'd0;
            end else begin
              asm_d = asm_q + 2'd1;
            end
            if (last_word) begin
              state_d = FLUSH;
            end
          end
        end
        FLUSH: begin
          if (handshake) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_q      <= '0;
      nk_q       <= 4'd4;
      nr_q       <= 4'd10;
      i_q        <= '0;
      mod_q      <= '0;
      rcon_q     <= 8'h01;
      asm_q      <= '0;
      r_q        <= '0;
      rk_data_q  <= '0;
      rk_idx_q   <= '0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      nk_q       <= nk_d;
      nr_q       <= nr_d;
      i_q        <= i_d;
      mod_q      <= mod_d;
      rcon_q     <= rcon_d;
      asm_q      <= asm_d;
      r_q        <= r_d;
      rk_data_q  <= rk_data_d;
      rk_idx_q   <= rk_idx_d;
      rk_valid_q <= rk_valid_d;
      rk_last_q  <= rk_last_d;
      err_q      <= err_d;
    end
  end

  // Sliding window of the most recent words, newest in slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) win_q[k] <= '0;
    end else if (adv) begin
      win_q[0] <= w_new;
      for (int k = 1; k < 8; k++) win_q[k] <= win_q[k-1];
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_hold
    // Park word gi of the current round until the 4th word completes it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q[gi] <= '0;
      end else if (adv && !load && (asm_q == 2'(gi))) begin
        hold_q[gi] <= w_new;
      end
    end
  end

  assign kif.busy     = (state_q != IDLE);
  assign kif.rk_valid = rk_valid_q;
  assign kif.rk_data  = rk_data_q;
  assign kif.rk_idx   = rk_idx_q;
  assign kif.rk_last  = rk_last_q;
  assign kif.err      = err_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule using FIPS-197 key-expansion vectors.
module tb_aes_key_schedule;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_schedule_if kif ();
  aes_key_schedule_if kif2 ();

  aes_key_schedule dut (.clk(clk), .rst_n(rst_n), .kif(kif));
  aes_key_schedule #(.ENABLE_192(1), .ENABLE_256(0)) dut2 (.clk(clk), .rst_n(rst_n), .kif(kif2));

  typedef struct {
    logic [3:0]   idx;
    logic         last;
    logic [127:0] data;
    bit           known;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [255:0] K128 = 256'h2b7e1516_28aed2a6_abf71588_09cf4f3c_00000000_00000000_00000000_00000000;
  localparam logic [255:0] K192 = 256'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b_00000000_00000000;
  localparam logic [255:0] K256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nr_of(input logic [1:0] len);
    return (len == 2'b00) ? 10 : (len == 2'b01) ? 12 : 14;
  endfunction

  // Hand-copied FIPS-197 round keys; other rounds are checked for order/last only.
  function automatic logic [127:0] known_rk(input logic [1:0] len, input int r, output bit known);
    known = 1'b1;
    known_rk = '0;
    case ({len, 4'(r)})
      {2'b00, 4'd0}:  known_rk = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
      {2'b00, 4'd1}:  known_rk = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
      {2'b00, 4'd10}: known_rk = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
      {2'b01, 4'd0}:  known_rk = 128'h8e73b0f7_da0e6452_c810f32b_809079e5;
      {2'b01, 4'd1}:  known_rk = 128'h62f8ead2_522c6b7b_fe0c91f7_2402f5a5;
      {2'b01, 4'd12}: known_rk = 128'he98ba06f_448c773c_8ecc7204_01002202;
      {2'b10, 4'd0}:  known_rk = 128'h603deb10_15ca71be_2b73aef0_857d7781;
      {2'b10, 4'd1}:  known_rk = 128'h1f352c07_3b6108d7_2d9810a3_0914dff4;
      {2'b10, 4'd2}:  known_rk = 128'h9ba35411_8e6925af_a51a8b5f_2067fcde;
      {2'b10, 4'd14}: known_rk = 128'hfe4890d1_e6188d0b_046df344_706c631e;
      default:        known = 1'b0;
    endcase
  endfunction

  task automatic push_job(input logic [1:0] len);
    exp_t e;
    int nr;
    nr = nr_of(len);
    for (int r = 0; r <= nr; r++) begin
      e.idx  = 4'(r);
      e.last = (r == nr);
      e.data = known_rk(len, r, e.known);
      sb.push_back(e);
    end
  endtask

  // Start accepted on the second edge; returns 1 time unit after it.
  task automatic start_job(input logic [1:0] len, input logic [255:0] key);
    @(posedge clk); #1;
    kif.start = 1'b1; kif.key_len = len; kif.key_in = key;
    @(posedge clk); #1;
    kif.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (kif.busy && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk("idle_timeout_busy", 128'(kif.busy), 128'd0);
    chk("sb_empty", 128'(sb.size()), 128'd0);
  endtask

  // Monitor: pops one expectation per handshake and checks stall stability.
  initial begin
    exp_t e;
    logic [127:0] prev_data;
    logic [3:0] prev_idx;
    logic stalled;
    stalled = 1'b0;
    prev_data = '0;
    prev_idx = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("hold_valid", 128'(kif.rk_valid), 128'd1);
          chk("hold_data", kif.rk_data, prev_data);
          chk("hold_idx", 128'(kif.rk_idx), 128'(prev_idx));
        end
        stalled = kif.rk_valid && !kif.rk_ready;
        prev_data = kif.rk_data;
        prev_idx = kif.rk_idx;
        if (kif.rk_valid && kif.rk_ready) begin
          $display("rk idx=%0d last=%0b data=%h", kif.rk_idx, kif.rk_last, kif.rk_data);
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_key: got idx %0d expected none", kif.rk_idx);
          end else begin
            e = sb.pop_front();
            chk("rk_idx", 128'(kif.rk_idx), 128'(e.idx));
            chk("rk_last", 128'(kif.rk_last), 128'(e.last));
            if (e.known) chk("rk_data", kif.rk_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit did;
    int c;
    kif.start = 1'b0; kif.key_len = 2'b00; kif.key_in = '0; kif.abort = 1'b0; kif.rk_ready = 1'b1;
    kif2.start = 1'b0; kif2.key_len = 2'b00; kif2.key_in = '0; kif2.abort = 1'b0; kif2.rk_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(kif.busy), 128'd0);
    chk("rst_valid", 128'(kif.rk_valid), 128'd0);
    chk("rst_last", 128'(kif.rk_last), 128'd0);
    chk("rst_err", 128'(kif.err), 128'd0);
    chk("rst_idx", 128'(kif.rk_idx), 128'd0);
    chk("rst_data", kif.rk_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // AES-128, full-rate consumer: latency and cadence
    push_job(2'b00);
    start_job(2'b00, K128);
    chk("start_err", 128'(kif.err), 128'd0);
    chk("start_valid", 128'(kif.rk_valid), 128'd0);
    chk("start_busy", 128'(kif.busy), 128'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("lat_t3_valid", 128'(kif.rk_valid), 128'd0);
    @(posedge clk); #1;
    chk("lat_t4_valid", 128'(kif.rk_valid), 128'd1);
    for (int k = 1; k <= 10; k++) begin
      repeat (4) @(posedge clk);
      #1;
      chk("cadence_valid", 128'(kif.rk_valid), 128'd1);
    end
    chk("busy_before_last_hs", 128'(kif.busy), 128'd1);
    @(posedge clk); #1;
    chk("busy_after_last_hs", 128'(kif.busy), 128'd0);
    chk("valid_after_last_hs", 128'(kif.rk_valid), 128'd0);
    chk("sb_empty_128", 128'(sb.size()), 128'd0);

    // AES-192 and AES-256, full-rate consumer
    push_job(2'b01);
    start_job(2'b01, K192);
    wait_idle(400);
    push_job(2'b10);
    start_job(2'b10, K256);
    wait_idle(400);

    // Backpressure: random ready plus one 20-cycle stall on rk3
    for (int j = 0; j < 3; j++) begin
      logic [1:0] len;
      len = 2'(j);
      kif.rk_ready = 1'b0;
      push_job(len);
      start_job(len, (j == 0) ? K128 : (j == 1) ? K192 : K256);
      did = 1'b0;
      c = 0;
      while (kif.busy && c < 2000) begin
        @(posedge clk); #1;
        c++;
        if (!did && kif.rk_valid && kif.rk_idx == 4'd3) begin
          kif.rk_ready = 1'b0;
          repeat (20) @(posedge clk);
          #1;
          chk("stall_valid", 128'(kif.rk_valid), 128'd1);
          chk("stall_idx", 128'(kif.rk_idx), 128'd3);
          did = 1'b1;
        end else begin
          kif.rk_ready = 1'($urandom_range(0, 1));
        end
      end
      kif.rk_ready = 1'b1;
      chk("bp_timeout_busy", 128'(kif.busy), 128'd0);
      chk("bp_sb_empty", 128'(sb.size()), 128'd0);
    end

    // Illegal key length
    start_job(2'b11, K128);
    chk("illegal_err", 128'(kif.err), 128'd1);
    chk("illegal_busy", 128'(kif.busy), 128'd0);
    @(posedge clk); #1;
    chk("illegal_err_pulse", 128'(kif.err), 128'd0);

    // AES-256 disabled instance
    @(posedge clk); #1;
    kif2.start = 1'b1; kif2.key_len = 2'b10; kif2.key_in = K256;
    @(posedge clk); #1;
    kif2.start = 1'b0;
    chk("dis256_err", 128'(kif2.err), 128'd1);
    chk("dis256_busy", 128'(kif2.busy), 128'd0);
    @(posedge clk); #1;
    chk("dis256_err_pulse", 128'(kif2.err), 128'd0);

    // Start while busy is ignored
    push_job(2'b00);
    start_job(2'b00, K128);
    repeat (10) @(posedge clk);
    #1;
    kif.start = 1'b1; kif.key_len = 2'b11; kif.key_in = K256;
    @(posedge clk); #1;
    kif.start = 1'b0;
    chk("busy_start_err", 128'(kif.err), 128'd0);
    chk("busy_start_busy", 128'(kif.busy), 128'd1);
    wait_idle(400);

    // Abort during rk3 generation, with a simultaneous start
    push_job(2'b00);
    start_job(2'b00, K128);
    repeat (14) @(posedge clk);
    #1;
    kif.abort = 1'b1; kif.start = 1'b1; kif.key_len = 2'b00; kif.key_in = K128;
    @(posedge clk); #1;
    kif.abort = 1'b0; kif.start = 1'b0;
    chk("abort_valid", 128'(kif.rk_valid), 128'd0);
    chk("abort_busy", 128'(kif.busy), 128'd0);
    sb.delete();
    @(posedge clk); #1;
    chk("abort_start_ignored", 128'(kif.busy), 128'd0);
    push_job(2'b00);
    start_job(2'b00, K128);
    wait_idle(400);

    // Reset pulsed mid-job
    push_job(2'b10);
    start_job(2'b10, K256);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_valid", 128'(kif.rk_valid), 128'd0);
    chk("midrst_busy", 128'(kif.busy), 128'd0);
    chk("midrst_idx", 128'(kif.rk_idx), 128'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_job(2'b00);
    start_job(2'b00, K128);
    wait_idle(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
